// File: rtl/booth_pkg.sv
// booth_pkg: shared types and build-dependent sizing for the Booth multiplier.
// BOOTH_RADIX4_EN selects radix-4 recoding; otherwise radix-2.
package booth_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    typedef enum logic [2:0] {OP_NONE, OP_ADD1, OP_SUB1, OP_ADD2, OP_SUB2} booth_op_e;

`ifdef BOOTH_RADIX4_EN
    localparam int BOOTH_BITS = 3;
    localparam int SHIFT = 2;

    // Operand extension width: WIDTH+1 rounded up to even.
    function automatic int ext_width(input int w);
        return (w + 2) / 2 * 2;
    endfunction

    // Two guard bits keep A from overflowing when +-2M is added.
    function automatic int acc_width(input int w);
        return ext_width(w) + 2;
    endfunction

    function automatic int iter_count(input int w);
        return ext_width(w) / 2;
    endfunction
`else
    localparam int BOOTH_BITS = 2;
    localparam int SHIFT = 1;

    function automatic int ext_width(input int w);
        return w + 1;
    endfunction

    function automatic int acc_width(input int w);
        return w + 1;
    endfunction

    function automatic int iter_count(input int w);
        return w + 1;
    endfunction
`endif

endpackage

// File: rtl/booth_recoder.sv
// booth_recoder: maps the inspected multiplier bits to a Booth operation.
// BOOTH_RADIX4_EN selects the radix-4 table; otherwise radix-2.
module booth_recoder
    import booth_pkg::*;
(
    input  logic [BOOTH_BITS-1:0] bits,
    output booth_op_e             op
);

`ifdef BOOTH_RADIX4_EN
    assign op = (bits == 3'b001 || bits == 3'b010) ? OP_ADD1 :
                (bits == 3'b011)                   ? OP_ADD2 :
                (bits == 3'b100)                   ? OP_SUB2 :
                (bits == 3'b101 || bits == 3'b110) ? OP_SUB1 : OP_NONE;
`else
    assign op = (bits == 2'b01) ? OP_ADD1 :
                (bits == 2'b10) ? OP_SUB1 : OP_NONE;
`endif

endmodule

// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential signed/unsigned Booth multiplier with valid/ready handshake.
// BOOTH_RADIX4_EN selects radix-4 recoding (fewer iterations); default is radix-2.
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int EW   = ext_width(WIDTH);
    localparam int AW   = acc_width(WIDTH);
    localparam int ITER = iter_count(WIDTH);
    localparam int CW   = $clog2(ITER + 1);
    localparam int TW   = AW + EW + 1;

    state_e          state, state_n;
    logic [AW-1:0]   m, acc, addend, sum;
    logic [EW-1:0]   q;
    logic            qm1;
    logic [CW-1:0]   cnt;
    logic [TW-1:0]   shifted;
    logic            accept, last;
    booth_op_e       op;

    booth_recoder u_recoder (
        .bits ({q[BOOTH_BITS-2:0], qm1}),
        .op   (op)
    );

    assign accept    = in_valid && state == IDLE;
    assign last      = state == BUSY && cnt == CW'(1);
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;

    // One add/sub and the arithmetic shift of {A,Q,Qm1} happen in the same cycle.
    always_comb begin
        addend  = op == OP_ADD1 ? m :
                  op == OP_SUB1 ? -m :
                  op == OP_ADD2 ? m << 1 :
                  op == OP_SUB2 ? -(m << 1) : '0;
        sum     = acc + addend;
        shifted = TW'($signed({sum, q, qm1}) >>> SHIFT);
    end

    always_comb begin
        state_n = accept                      ? BUSY :
                  last                        ? DONE :
                  (state == DONE && out_ready) ? IDLE : state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m       <= '0;
            acc     <= '0;
            q       <= '0;
            qm1     <= 1'b0;
            cnt     <= '0;
            product <= '0;
        end else if (accept) begin
            m   <= {{(AW-WIDTH){is_signed & a[WIDTH-1]}}, a};
            q   <= {{(EW-WIDTH){is_signed & b[WIDTH-1]}}, b};
            acc <= '0;
            qm1 <= 1'b0;
            cnt <= CW'(ITER);
        end else if (state == BUSY) begin
            acc <= shifted[TW-1 -: AW];
            q   <= shifted[EW:1];
            qm1 <= shifted[0];
            cnt <= cnt - CW'(1);
            if (last) product <= shifted[2*WIDTH:1];
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq: directed and random checks of booth_mult_seq (WIDTH=8).
// Define BOOTH_RADIX4_EN to check the radix-4 build.
module tb_booth_mult_seq;

`ifdef BOOTH_RADIX4_EN
    localparam int ITER = 5;
`else
    localparam int ITER = 9;
`endif
    localparam int N = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        is_signed = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] product;
    logic        busy;

    int checks = 0;
    int errors = 0;

    booth_mult_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y, input logic s);
        logic signed [15:0] sx, sy;
        sx = s ? {{8{x[7]}}, x} : {8'h00, x};
        sy = s ? {{8{y[7]}}, y} : {8'h00, y};
        return 16'(sx * sy);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Runs one operation from IDLE; flips is_signed after accept to show it is not re-sampled.
    task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic s,
                          output logic [15:0] p, output int lat);
        a = x; b = y; is_signed = s; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        is_signed = ~s;
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick;
            lat++;
        end
        p = product;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        logic [15:0] p;
        int lat;
        rst = 1'b1;
        repeat (3) tick;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 16'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: in_ready=%b out_valid=%b product=%h busy=%b, want 1 0 0000 0",
                     in_ready, out_valid, product, busy);
        end
        rst = 1'b0;
        tick;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 16'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: in_ready=%b out_valid=%b product=%h busy=%b, want 1 0 0000 0",
                     in_ready, out_valid, product, busy);
        end
        run_op(8'd3, 8'hFC, 1'b1, p, lat);
        checks++;
        if (p !== 16'hFFF4) begin
            errors++;
            $display("FAIL first_product: got %h want fff4", p);
        end
        checks++;
        if (lat !== ITER) begin
            errors++;
            $display("FAIL latency: got %0d want %0d", lat, ITER);
        end
    endtask

    task automatic test_corners;
        logic [7:0]  va [4] = '{8'h80, 8'hFF, 8'd200, 8'h00};
        logic [7:0]  vb [4] = '{8'h80, 8'hFF, 8'h00,  8'd77};
        logic        vs [4] = '{1'b1,  1'b0,  1'b0,   1'b1};
        logic [15:0] ve [4] = '{16'h4000, 16'hFE01, 16'h0000, 16'h0000};
        logic [15:0] p;
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], vs[i], p, lat);
            checks++;
            if (p !== ve[i] || lat !== ITER) begin
                errors++;
                $display("FAIL corner%0d: product=%h lat=%0d want %h lat=%0d", i, p, lat, ve[i], ITER);
            end
        end
    endtask

    task automatic test_stall;
        logic [15:0] p;
        int lat;
        bit bad;
        a = 8'd5; b = 8'd9; is_signed = 1'b0; in_valid = 1'b1;
        tick;
        a = 8'd99; b = 8'd99;
        tick;
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_flags: in_ready=%b busy=%b want 0 1", in_ready, busy);
        end
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            tick;
            lat++;
        end
        checks++;
        if (lat !== ITER) begin
            errors++;
            $display("FAIL stall_latency: got %0d want %0d", lat, ITER);
        end
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_valid = i[0];
            if (out_valid !== 1'b1 || product !== 16'd45 || in_ready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
            tick;
        end
        checks++;
        if (bad || out_valid !== 1'b1 || product !== 16'd45) begin
            errors++;
            $display("FAIL stall_hold: out_valid=%b product=%h want 1 002d stable", out_valid, product);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
        run_op(8'd12, 8'd11, 1'b0, p, lat);
        checks++;
        if (p !== 16'd132 || lat !== ITER) begin
            errors++;
            $display("FAIL after_stall: product=%h lat=%0d want 0084 lat=%0d", p, lat, ITER);
        end
    endtask

    task automatic test_abort;
        logic [15:0] p;
        int lat;
        bit rose;
        a = 8'd100; b = 8'd100; is_signed = 1'b0; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (3) tick;
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || product !== 16'h0) begin
            errors++;
            $display("FAIL abort_reset: in_ready=%b busy=%b product=%h want 1 0 0000", in_ready, busy, product);
        end
        tick;
        rst = 1'b0;
        rose = 1'b0;
        for (int i = 0; i < ITER + 5; i++) begin
            if (out_valid !== 1'b0) rose = 1'b1;
            tick;
        end
        checks++;
        if (rose || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_quiet: out_valid rose=%b in_ready=%b want 0 1", rose, in_ready);
        end
        run_op(8'd7, 8'd6, 1'b0, p, lat);
        checks++;
        if (p !== 16'd42 || lat !== ITER) begin
            errors++;
            $display("FAIL after_abort: product=%h lat=%0d want 002a lat=%0d", p, lat, ITER);
        end
    endtask

    task automatic test_sweep;
        logic [7:0] v [8] = '{8'd0, 8'd1, 8'd2, 8'd127, 8'd128, 8'd129, 8'd254, 8'd255};
        logic [15:0] p, e;
        int lat;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 8; i++)
                for (int j = 0; j < 8; j++) begin
                    run_op(v[i], v[j], s[0], p, lat);
                    e = ref_mul(v[i], v[j], s[0]);
                    checks++;
                    if (p !== e || lat !== ITER) begin
                        errors++;
                        $display("FAIL sweep s=%0d a=%h b=%h: product=%h lat=%0d want %h lat=%0d",
                                 s, v[i], v[j], p, lat, e, ITER);
                    end
                end
    endtask

    task automatic test_back_to_back;
        logic [7:0]  ra [N];
        logic [7:0]  rb [N];
        logic        rs [N];
        logic [15:0] expq [N];
        int nin, nout, cyc, last_acc;
        for (int i = 0; i < N; i++) begin
            ra[i] = 8'($urandom);
            rb[i] = 8'($urandom);
            rs[i] = 1'($urandom);
        end
        nin = 0; nout = 0; cyc = 0; last_acc = -1;
        out_ready = 1'b1;
        while (nout < N && cyc < N * (ITER + 2) + 100) begin
            if (out_valid) begin
                checks++;
                if (product !== expq[nout]) begin
                    errors++;
                    $display("FAIL b2b op%0d: product=%h want %h", nout, product, expq[nout]);
                end
                nout++;
            end
            if (nin < N) begin
                in_valid = 1'b1;
                a = ra[nin]; b = rb[nin]; is_signed = rs[nin];
            end else begin
                in_valid = 1'b0;
            end
            if (in_ready && nin < N) begin
                expq[nin] = ref_mul(ra[nin], rb[nin], rs[nin]);
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc !== ITER + 2) begin
                        errors++;
                        $display("FAIL b2b_spacing op%0d: got %0d want %0d", nin, cyc - last_acc, ITER + 2);
                    end
                end
                last_acc = cyc;
                nin++;
            end
            tick;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (nout !== N) begin
            errors++;
            $display("FAIL b2b_count: got %0d results want %0d", nout, N);
        end
    endtask

    initial begin
        test_reset;
        test_corners;
        test_stall;
        test_abort;
        test_sweep;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
